// File: rtl/minrv32_regfile.sv
// minrv32_regfile: minrv32 integer register file with hardwired x0 and an RV32E mode with illegal-index detection.
//
// After reset, a scrub sequencer clears every register and loads the stack pointer.
// When MINRV32_REGFILE_BYPASS_EN is defined, a read of the register being written
// in the same cycle returns the new data. Otherwise the read returns the old value.
//
// Ports:
//   clk           core clock
//   resetn        synchronous active-low reset
//   init_busy     high while the scrub runs
//   rd_addr_valid write request
//   rd_addr       write index
//   rd_wdata      write data
//   rs_addr_valid per-port read request
//   rs_addr       read indices; port p uses [5p+4:5p]
//   rs_rdata      registered read data; port p uses [XLEN*p +: XLEN]
//   wr_drop       one-cycle pulse: a write was discarded
//   illegal_idx   one-cycle pulse: an index >= NREGS arrived on a valid port
module minrv32_regfile #(
  parameter int          XLEN      = 32,
  parameter int          NREGS     = 32,
  parameter int          NRPORTS   = 2,
  parameter logic [31:0] STACKADDR = 32'h0001_0000,
  parameter int          SP_INDEX  = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    init_busy,
  input  logic                    rd_addr_valid,
  input  logic [4:0]              rd_addr,
  input  logic [XLEN-1:0]         rd_wdata,
  input  logic [NRPORTS-1:0]      rs_addr_valid,
  input  logic [5*NRPORTS-1:0]    rs_addr,
  output logic [XLEN*NRPORTS-1:0] rs_rdata,
  output logic                    wr_drop,
  output logic                    illegal_idx
);
  localparam int AW = $clog2(NREGS);
  typedef enum logic {SCRUB, READY} state_t;
  state_t state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] rd_val [NRPORTS];
  logic [4:0] idx [NRPORTS];
  logic wr_ok, wr_bad, rd_bad;
  // NREGS is either 16 or 32, so bit 4 alone tells whether an index is in range.
  function automatic logic legal(input logic [4:0] a);
    return NREGS == 32 || !a[4];
  endfunction
  always_comb begin
    state_nx = (state == SCRUB && cnt == AW'(NREGS - 1)) ? READY : state;
    cnt_nx = (state == SCRUB) ? cnt + 1'b1 : cnt;
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      state <= SCRUB;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  assign init_busy = (state == SCRUB);
  assign wr_ok = state == READY && rd_addr_valid && rd_addr != 5'd0 && legal(rd_addr);
  assign wr_bad = state == READY && rd_addr_valid && !legal(rd_addr);
  always_comb begin
    rd_bad = 1'b0;
    for (int p = 0; p < NRPORTS; p++) begin
      idx[p] = rs_addr[5*p +: 5];
      rd_bad = rd_bad | (rs_addr_valid[p] && !legal(idx[p]));
      rd_val[p] = (state != READY || idx[p] == 5'd0 || !legal(idx[p])) ? '0 : regs[idx[p][AW-1:0]];
`ifdef MINRV32_REGFILE_BYPASS_EN
      rd_val[p] = (wr_ok && rd_addr == idx[p]) ? rd_wdata : rd_val[p];
`endif
    end
    rd_bad = rd_bad && state == READY;
  end
  always_ff @(posedge clk)
    if (resetn && state == SCRUB)
      regs[cnt] <= (cnt == AW'(SP_INDEX)) ? XLEN'(STACKADDR) : '0;
    else if (resetn && wr_ok)
      regs[rd_addr[AW-1:0]] <= rd_wdata;
  always_ff @(posedge clk)
    if (!resetn) begin
      rs_rdata <= '0;
      wr_drop <= 1'b0;
      illegal_idx <= 1'b0;
    end else begin
      wr_drop <= rd_addr_valid && (state == SCRUB || !legal(rd_addr));
      illegal_idx <= wr_bad || rd_bad;
      for (int p = 0; p < NRPORTS; p++)
        if (rs_addr_valid[p]) rs_rdata[XLEN*p +: XLEN] <= rd_val[p];
    end
endmodule
